// File: rtl/light_pkg.sv
// light_pkg: shared definitions for the light_monitor slice.
//   - Lamp color encodings (one-hot RED/YELLOW/GREEN, DARK = all off)
//   - Fault code enumeration reported on fault_code
//   - Monitor FSM state encoding
//   - Field width and bit positions of the two directions on the lights bus
package light_pkg;

    localparam int FIELD_W = 3;
    localparam int A_LSB   = 0;
    localparam int B_LSB   = FIELD_W;

    localparam logic [FIELD_W-1:0] DARK   = 3'h0;
    localparam logic [FIELD_W-1:0] RED    = 3'h1;
    localparam logic [FIELD_W-1:0] YELLOW = 3'h2;
    localparam logic [FIELD_W-1:0] GREEN  = 3'h4;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENC      = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQ      = 3'd3,
        FC_DWELL    = 3'd4,
        FC_STUCK    = 3'd5
    } fault_code_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } mon_state_e;

    // A direction is "moving" when it shows YELLOW or GREEN; two moving
    // directions at once is a conflict.
    function automatic logic is_moving(input logic [FIELD_W-1:0] f);
        return (f == YELLOW) || (f == GREEN);
    endfunction

endpackage

// File: rtl/light_dir_checker.sv
// light_dir_checker: per-direction capture and rule checking.
// Registers one color field, keeps its previous value and the run length
// (dwell) of the current and previous colors, and flags encoding, sequence,
// dwell and stuck-color violations on the captured value.
// Optional feature: `LIGHT_MONITOR_STUCK_EN compiles in the stuck-color check;
// without it stuck_err is tied low.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   field        - raw color field from the lights bus
//   cur          - registered field (feeds the lamp path)
//   enc_err      - cur is neither one-hot nor DARK
//   seq_err      - illegal GREEN->RED, YELLOW->GREEN or RED->YELLOW step
//   dwell_err    - GREEN/YELLOW left before its minimum dwell
//   stuck_err    - a lit color has been held for MAX_DWELL samples
module light_dir_checker
    import light_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 4,
    parameter int MAX_DWELL  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FIELD_W-1:0] field,
    output logic [FIELD_W-1:0] cur,
    output logic               enc_err,
    output logic               seq_err,
    output logic               dwell_err,
    output logic               stuck_err
);

    localparam int              DW       = $clog2(MAX_DWELL + 1);
    localparam logic [DW-1:0]   DW_MAX   = DW'(MAX_DWELL);
    localparam logic [DW-1:0]   DW_MIN_G = DW'(MIN_GREEN);
    localparam logic [DW-1:0]   DW_MIN_Y = DW'(MIN_YELLOW);

    logic [FIELD_W-1:0] prev;
    logic [DW-1:0]      dwell;
    logic [DW-1:0]      prev_dwell;
    logic               changed;

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (v == DW_MAX) ? v : v + DW'(1);
    endfunction

    // Capture stage: prev_dwell holds the final run length of prev, which is
    // what the dwell rule needs in the cycle the color changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= DARK;
            prev       <= DARK;
            dwell      <= '0;
            prev_dwell <= '0;
        end else begin
            cur        <= field;
            prev       <= cur;
            prev_dwell <= dwell;
            if (field != cur) begin
                dwell <= DW'(1);
            end else begin
                dwell <= sat_inc(dwell);
            end
        end
    end

    assign changed = (cur != prev);

    assign enc_err = !((cur == DARK) || (cur == RED) || (cur == YELLOW) || (cur == GREEN));

    assign seq_err = ((prev == GREEN)  && (cur == RED))    ||
                     ((prev == YELLOW) && (cur == GREEN))  ||
                     ((prev == RED)    && (cur == YELLOW));

    assign dwell_err = changed &&
                       (((prev == GREEN)  && (prev_dwell < DW_MIN_G)) ||
                        ((prev == YELLOW) && (prev_dwell < DW_MIN_Y)));

`ifdef LIGHT_MONITOR_STUCK_EN
    assign stuck_err = (dwell == DW_MAX) && (cur != DARK);
`else
    assign stuck_err = 1'b0;
`endif

endmodule

// File: rtl/light_monitor.sv
// light_monitor: receive-side checker and lamp driver for the 6-bit lights
// bus. Forwards the captured colors to the lamps while the bus is legal; on
// any violation latches a fault code and flashes both directions RED/DARK
// until clr_fault is pulsed with a legal bus.
// Optional feature: `LIGHT_MONITOR_STUCK_EN enables the stuck-color check
// (fault code 5); otherwise MAX_DWELL only sizes the dwell counters.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   lights       - [2:0] direction A, [5:3] direction B color fields
//   clr_fault    - single-cycle request to leave the fault state
//   lamp_a/b     - registered lamp drive per direction
//   fault        - fault latched
//   fault_code   - 0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 DWELL, 5 STUCK
module light_monitor
    import light_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 4,
    parameter int MAX_DWELL  = 1024,
    parameter int FLASH_HALF = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*FIELD_W-1:0] lights,
    input  logic                 clr_fault,
    output logic [FIELD_W-1:0]   lamp_a,
    output logic [FIELD_W-1:0]   lamp_b,
    output logic                 fault,
    output logic [2:0]           fault_code
);

    localparam int            FW      = $clog2(2 * FLASH_HALF);
    localparam logic [FW-1:0] FL_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FL_HALF = FW'(FLASH_HALF);

    logic [FIELD_W-1:0] cur_a, cur_b;
    logic               enc_a, seq_a, dwell_a, stuck_a;
    logic               enc_b, seq_b, dwell_b, stuck_b;
    logic               conflict;
    fault_code_e        viol;

    mon_state_e         state_q, state_d;
    fault_code_e        code_q, code_d;
    logic [FW-1:0]      flash_q, flash_d;
    logic [FIELD_W-1:0] lamp_a_q, lamp_a_d;
    logic [FIELD_W-1:0] lamp_b_q, lamp_b_d;

    function automatic logic [FW-1:0] flash_inc(input logic [FW-1:0] v);
        return (v == FL_LAST) ? '0 : v + FW'(1);
    endfunction

    function automatic logic [FIELD_W-1:0] flash_lamp(input logic [FW-1:0] v);
        return (v < FL_HALF) ? RED : DARK;
    endfunction

    light_dir_checker #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_DWELL (MAX_DWELL)
    ) u_dir_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .field    (lights[A_LSB +: FIELD_W]),
        .cur      (cur_a),
        .enc_err  (enc_a),
        .seq_err  (seq_a),
        .dwell_err(dwell_a),
        .stuck_err(stuck_a)
    );

    light_dir_checker #(
        .MIN_GREEN (MIN_GREEN),
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_DWELL (MAX_DWELL)
    ) u_dir_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .field    (lights[B_LSB +: FIELD_W]),
        .cur      (cur_b),
        .enc_err  (enc_b),
        .seq_err  (seq_b),
        .dwell_err(dwell_b),
        .stuck_err(stuck_b)
    );

    // Check stage: both directions' flags from cur/prev, lowest code wins.
    assign conflict = is_moving(cur_a) && is_moving(cur_b);

    always_comb begin
        viol = FC_NONE;
        if (enc_a || enc_b) begin
            viol = FC_ENC;
        end else if (conflict) begin
            viol = FC_CONFLICT;
        end else if (seq_a || seq_b) begin
            viol = FC_SEQ;
        end else if (dwell_a || dwell_b) begin
            viol = FC_DWELL;
        end else if (stuck_a || stuck_b) begin
            viol = FC_STUCK;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        flash_d  = flash_q;
        lamp_a_d = cur_a;
        lamp_b_d = cur_b;
        case (state_q)
            ST_NORMAL: begin
                if (viol != FC_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = viol;
                    flash_d = '0;
                end
            end
            ST_FAULT: begin
                if (clr_fault && (viol != FC_NONE)) begin
                    // A clear that coincides with a new violation re-arms
                    // the fault with the fresh code instead of leaving.
                    code_d  = viol;
                    flash_d = '0;
                end else if (clr_fault) begin
                    state_d = ST_NORMAL;
                    code_d  = FC_NONE;
                    flash_d = '0;
                end else begin
                    flash_d = flash_inc(flash_q);
                end
            end
            default: begin
                state_d = ST_NORMAL;
                code_d  = FC_NONE;
                flash_d = '0;
            end
        endcase
        // Lamps follow the counter value being registered so the first
        // faulted edge already drives RED.
        if (state_d == ST_FAULT) begin
            lamp_a_d = flash_lamp(flash_d);
            lamp_b_d = flash_lamp(flash_d);
        end
    end

    // Output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            code_q   <= FC_NONE;
            flash_q  <= '0;
            lamp_a_q <= RED;
            lamp_b_q <= RED;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            flash_q  <= flash_d;
            lamp_a_q <= lamp_a_d;
            lamp_b_q <= lamp_b_d;
        end
    end

    assign lamp_a     = lamp_a_q;
    assign lamp_b     = lamp_b_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_light_monitor.sv
// tb_light_monitor: scoreboard bench for light_monitor. A reference model
// keeps the history of captured samples and derives every rule from run
// lengths in that history; each clock it pushes the expected outputs, and a
// monitor compares them one time unit after the edge. Directed sequences
// plus randomized traffic drive the inputs.
module tb_light_monitor;
    import light_pkg::*;

    localparam int MIN_G = 8;
    localparam int MIN_Y = 4;
    localparam int MAXD  = 32;
    localparam int HALF  = 16;
    localparam int HIST  = 48;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] lights = 6'h0;
    logic       clr_fault = 1'b0;
    logic [2:0] lamp_a, lamp_b, fault_code;
    logic       fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    light_monitor #(
        .MIN_GREEN (MIN_G),
        .MIN_YELLOW(MIN_Y),
        .MAX_DWELL (MAXD),
        .FLASH_HALF(HALF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lights    (lights),
        .clr_fault (clr_fault),
        .lamp_a    (lamp_a),
        .lamp_b    (lamp_b),
        .fault     (fault),
        .fault_code(fault_code)
    );

    // ---------------- reference model ----------------
    logic [2:0] ha[$];
    logic [2:0] hb[$];
    logic       m_fault;
    int         m_code;
    int         m_flash;
    logic [2:0] m_la, m_lb;
    logic [9:0] sb[$];

    // Number of identical samples ending at index idx.
    function automatic int run_end(input logic [2:0] h[$], input int idx);
        int n = 0;
        for (int i = idx; i >= 0; i--) begin
            if (h[i] == h[idx]) n++;
            else break;
        end
        return n;
    endfunction

    // Lowest violation code raised by one direction's history (0 = none).
    function automatic int field_code(input logic [2:0] h[$]);
        int         n = h.size();
        logic [2:0] c = h[n-1];
        logic [2:0] p = h[n-2];
        int         rl;
        if (!(c inside {3'h0, 3'h1, 3'h2, 3'h4})) return 1;
        if ((p == 3'h4 && c == 3'h1) || (p == 3'h2 && c == 3'h4) || (p == 3'h1 && c == 3'h2))
            return 3;
        if (c != p) begin
            rl = run_end(h, n - 2);
            if ((p == 3'h4 && rl < MIN_G) || (p == 3'h2 && rl < MIN_Y)) return 4;
        end
`ifdef LIGHT_MONITOR_STUCK_EN
        if (c != 3'h0 && run_end(h, n - 1) >= MAXD) return 5;
`endif
        return 0;
    endfunction

    function automatic int violation();
        int codes[3];
        int v = 0;
        logic [2:0] ca = ha[ha.size()-1];
        logic [2:0] cb = hb[hb.size()-1];
        codes[0] = field_code(ha);
        codes[1] = field_code(hb);
        codes[2] = ((ca == 3'h2 || ca == 3'h4) && (cb == 3'h2 || cb == 3'h4)) ? 2 : 0;
        foreach (codes[i]) if (codes[i] != 0 && (v == 0 || codes[i] < v)) v = codes[i];
        return v;
    endfunction

    task automatic model_step();
        int v;
        if (!rst_n) begin
            ha = {};  hb = {};
            ha.push_back(3'h0); ha.push_back(3'h0);
            hb.push_back(3'h0); hb.push_back(3'h0);
            m_fault = 1'b0; m_code = 0; m_flash = 0;
            m_la = 3'h1; m_lb = 3'h1;
        end else begin
            v = violation();
            if (!m_fault) begin
                if (v != 0) begin m_fault = 1'b1; m_code = v; m_flash = 0; end
            end else if (clr_fault) begin
                if (v != 0) begin m_code = v; m_flash = 0; end
                else begin m_fault = 1'b0; m_code = 0; end
            end else begin
                m_flash = (m_flash + 1) % (2 * HALF);
            end
            if (m_fault) begin
                m_la = (m_flash < HALF) ? 3'h1 : 3'h0;
                m_lb = m_la;
            end else begin
                m_la = ha[ha.size()-1];
                m_lb = hb[hb.size()-1];
            end
            ha.push_back(lights[2:0]);
            hb.push_back(lights[5:3]);
            if (ha.size() > HIST) begin void'(ha.pop_front()); void'(hb.pop_front()); end
        end
        sb.push_back({m_la, m_lb, m_fault, 3'(m_code)});
    endtask

    always @(posedge clk) model_step();

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [9:0] e;
        logic [9:0] a;
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty at %0t: no expected entry", $time);
        end else begin
            e = sb.pop_front();
            a = {lamp_a, lamp_b, fault, fault_code};
            if (a !== e) begin
                bad++;
                $display("FAIL sb_cycle at %0t: got la=%h lb=%h f=%b code=%0d want la=%h lb=%h f=%b code=%0d",
                         $time, a[9:7], a[6:4], a[3], a[2:0], e[9:7], e[6:4], e[3], e[2:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] l, input logic c);
        lights    = l;
        clr_fault = c;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(6'h0, 1'b0);
        step(6'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic logic [5:0] pack(input logic [2:0] b, input logic [2:0] a);
        return {b, a};
    endfunction

    initial begin
        logic [5:0] lv;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_lamp_a", int'(lamp_a), 1);
        chk("reset_lamp_b", int'(lamp_b), 1);
        chk("reset_fault", int'(fault), 0);
        chk("reset_code", int'(fault_code), 0);
        step(6'h0, 1'b0);
        rst_n = 1'b1;

        // Legal cycle: A G8 Y4 R, then B G8 Y4 R.
        repeat (8) step(pack(RED, GREEN), 1'b0);
        repeat (4) step(pack(RED, YELLOW), 1'b0);
        repeat (2) step(pack(RED, RED), 1'b0);
        repeat (8) step(pack(GREEN, RED), 1'b0);
        chk("legal_lamp_b_green", int'(lamp_b), int'(GREEN));
        repeat (4) step(pack(YELLOW, RED), 1'b0);
        repeat (3) step(pack(RED, RED), 1'b0);
        chk("legal_no_fault", int'(fault), 0);

        // Encoding fault and flash pattern, then clear behaviour.
        do_reset();
        step(6'h3F, 1'b0);
        step(6'h00, 1'b0);
        chk("enc_fault", int'(fault), 1);
        chk("enc_code", int'(fault_code), 1);
        chk("enc_flash_red", int'(lamp_a), int'(RED));
        repeat (16) step(6'h00, 1'b0);
        chk("flash_dark", int'(lamp_b), int'(DARK));
        repeat (16) step(6'h00, 1'b0);
        chk("flash_red_again", int'(lamp_a), int'(RED));
        step(6'h3F, 1'b0);
        step(6'h3F, 1'b1);
        chk("clr_with_viol_fault", int'(fault), 1);
        chk("clr_with_viol_code", int'(fault_code), 1);
        step(6'h00, 1'b0);
        step(6'h00, 1'b0);
        step(6'h00, 1'b1);
        chk("clr_fault_cleared", int'(fault), 0);
        chk("clr_code_zero", int'(fault_code), 0);
        step(6'h00, 1'b0);
        chk("clr_lamp_follows", int'(lamp_a), int'(DARK));

        // Conflict.
        do_reset();
        step(pack(GREEN, GREEN), 1'b0);
        step(6'h00, 1'b0);
        chk("conflict_code", int'(fault_code), 2);

        // Sequence: A GREEN -> RED.
        do_reset();
        repeat (8) step(pack(RED, GREEN), 1'b0);
        step(pack(RED, RED), 1'b0);
        step(pack(RED, RED), 1'b0);
        chk("seq_code", int'(fault_code), 3);

        // Dwell: GREEN x7 then YELLOW is short; x8 is legal.
        do_reset();
        repeat (7) step(pack(RED, GREEN), 1'b0);
        step(pack(RED, YELLOW), 1'b0);
        step(pack(RED, YELLOW), 1'b0);
        chk("dwell_short_code", int'(fault_code), 4);
        do_reset();
        repeat (8) step(pack(RED, GREEN), 1'b0);
        repeat (4) step(pack(RED, YELLOW), 1'b0);
        step(pack(RED, RED), 1'b0);
        chk("dwell_exact_ok", int'(fault), 0);
        do_reset();
        repeat (3) step(pack(RED, YELLOW), 1'b0);
        step(pack(RED, RED), 1'b0);
        step(pack(RED, RED), 1'b0);
        chk("yellow_short_code", int'(fault_code), 4);

        // Stuck color.
        do_reset();
        repeat (34) step(pack(DARK, RED), 1'b0);
`ifdef LIGHT_MONITOR_STUCK_EN
        chk("stuck_code", int'(fault_code), 5);
`else
        chk("stuck_disabled", int'(fault), 0);
`endif

        // Randomized traffic.
        do_reset();
        lv = 6'h0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [2:0] col;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                lv = 6'($urandom);
            end else if (r < 35) begin
                case ($urandom_range(0, 3))
                    0: col = DARK;
                    1: col = RED;
                    2: col = YELLOW;
                    default: col = GREEN;
                endcase
                if ($urandom_range(0, 1) == 0) lv[2:0] = col;
                else lv[5:3] = col;
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(lv, ($urandom_range(0, 7) == 0));
            end
        end

        step(6'h0, 1'b0);
        step(6'h0, 1'b0);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
# light_monitor

Receive-side checker and lamp driver for the 6-bit `lights` bus produced by the intersection controller FSM. It decodes the two per-direction color fields and checks encoding, cross-direction conflicts, color sequencing and dwell times. While the bus is legal it forwards the colors to the lamp outputs. On any violation it latches a fault code and forces both directions to flashing red until software clears it.

## Interface
Parameters:
- `MIN_GREEN`, 8: minimum consecutive cycles a field must hold GREEN before leaving it.
- `MIN_YELLOW`, 4: minimum consecutive cycles a field must hold YELLOW before leaving it.
- `MAX_DWELL`, 1024: stuck-color timeout in cycles. Only used with `LIGHT_MONITOR_STUCK_EN`.
- `FLASH_HALF`, 16: half-period, in cycles, of the fault flash.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `lights`, in, 6: `[2:0]` is direction A, `[5:3]` is direction B. Each field is one-hot RED=3'h1, YELLOW=3'h2, GREEN=3'h4, or DARK=3'h0.
- `clr_fault`, in, 1: single-cycle request to leave the fault state.
- `lamp_a`, out, 3: registered drive for the direction A lamps.
- `lamp_b`, out, 3: registered drive for the direction B lamps.
- `fault`, out, 1: fault latched.
- `fault_code`, out, 3: 0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 DWELL, 5 STUCK.

## Operation
- **Capture stage:** `lights` is registered into `cur`. The previous `cur` is kept as `prev`. Both reset to DARK.
- **Per-field checks**, evaluated on `cur` vs `prev`:
  - ENC: the field is not one-hot and not DARK. This includes all-ones 3'h7.
  - SEQ: the transition is GREEN→RED, YELLOW→GREEN or RED→YELLOW. Transitions to or from DARK are legal.
  - DWELL: the field leaves GREEN with dwell < `MIN_GREEN`, or leaves YELLOW with dwell < `MIN_YELLOW`.
  - STUCK: dwell reaches `MAX_DWELL` while the field is not DARK.
- **Dwell counter**, one per field:
  - Set to 1 on any change of the field.
  - Otherwise increments and saturates at `MAX_DWELL`.
  - Width is `$clog2(MAX_DWELL+1)`.
- **CONFLICT:** both fields are YELLOW or GREEN at the same time.
- **Priority:** when several violations occur in the same cycle, the lowest code wins.
- **FSM states:**
  - NORMAL (reset state): `lamp_a`/`lamp_b` follow the `cur` fields. Any violation moves to FAULT and latches the code.
  - FAULT:
    - `fault`=1 and `fault_code` is sticky; later violations do not overwrite it.
    - A flash counter starts at 0 on entry and wraps at 2·`FLASH_HALF`−1.
    - Both lamps are RED while the counter < `FLASH_HALF`, and DARK otherwise.
    - Capture, dwell and history keep tracking the input.
    - On `clr_fault` with no violation in the same cycle: go to NORMAL, clear `fault_code` to 0 and `fault` to 0.
    - On `clr_fault` with a violation in the same cycle: stay in FAULT, reload `fault_code` with the new code, and restart the flash counter at 0.
- **Reset mid-operation:** reset returns everything to the reset values immediately. A fault is not preserved across reset.

## Timing
- **Reset values:** `lamp_a`=`lamp_b`=3'h1 (RED), `fault`=0, `fault_code`=0. `cur`/`prev`=DARK, dwell counters=0, flash counter=0.
- **Latency:** `lights` sampled at edge N appears on `lamp_*` after edge N+1.
- **Fault detection:** a violation caused by the sample at edge N sets `fault`/`fault_code` after edge N+1. Flash RED is driven from that same edge.
- **Clear:** `clr_fault` sampled at edge M takes effect after edge M. Lamps show `cur` from edge M+1 onward.
- **Dwell boundary:** a field that holds GREEN for exactly `MIN_GREEN` samples is legal. `MIN_GREEN`−1 samples is DWELL. The same rule applies to YELLOW.
- **No handshake:** `lights` is sampled every cycle.

## Configuration
- `LIGHT_MONITOR_STUCK_EN` defined: the STUCK check is compiled in and code 5 is reachable.
- Undefined: no STUCK logic; `MAX_DWELL` only sizes the saturating counter, and code 5 is never produced.

## Structure
- Package `light_pkg` holds:
  - the color constants RED/YELLOW/GREEN/DARK;
  - the fault-code enum;
  - the field width (3) and field slicing constants.
- Sub-module `light_dir_checker`, instantiated twice (A, B):
  - holds that field's `cur`/`prev`, dwell counter, and ENC/SEQ/DWELL/STUCK flags.
- The top level holds the CONFLICT check, priority encoding, NORMAL/FAULT FSM, flash counter and output registers.

## Test plan
- Reset, then A: GREEN×8 → YELLOW×4 → RED with B RED, then B GREEN → `lamp_*` mirror the input 2 edges late; `fault` stays 0.
- `lights`=6'h3F → `fault`=1, `fault_code`=1 two edges later. Lamps alternate RED/DARK every 16 cycles.
- A GREEN, B GREEN simultaneously → `fault_code`=2. A GREEN→RED directly → `fault_code`=3.
- A GREEN×7 then YELLOW → `fault_code`=4. GREEN×8 then YELLOW → no fault.
- In FAULT, pulse `clr_fault` while the input is legal → NORMAL, code 0. Pulse it while the input is 6'h3F → stays in FAULT, flash restarts.
- With `LIGHT_MONITOR_STUCK_EN` and `MAX_DWELL`=32, hold A RED 32 cycles → `fault_code`=5. Without the macro → no fault.
